// File: rtl/router_pkt_tx.sv
// Store-and-forward packet source for the router input port.
// A command {dest, len} is accepted, the whole payload is buffered, then the
// header, payload and parity bytes are driven onto the router wire under busy.
module router_pkt_tx #(
  parameter int unsigned MAX_LEN = 63,
  parameter int unsigned GAP     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_dest,
  input  logic [5:0]  cmd_len,
  input  logic        pay_valid,
  output logic        pay_ready,
  input  logic [7:0]  pay_data,
  input  logic        busy,
  output logic        pkt_valid,
  output logic [7:0]  data_out,
  output logic        tx_done,
  output logic        err_cmd,
  output logic [15:0] pkt_count
);

  localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StHeader,
    StPayload,
    StParity,
    StGap
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    header_q, header_d;
  logic [7:0]    parity_q, parity_d;
  logic [5:0]    wcnt_q, wcnt_d;
  logic [5:0]    rcnt_q, rcnt_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic          tx_done_q, tx_done_d;
  logic          err_q, err_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          rst_q;
  logic [7:0]    mem_q [MAX_LEN];
  logic          mem_we;
  logic          cmd_ok;
  logic [5:0]    len_last;

  assign cmd_ok   = (cmd_dest != 2'd3) && (cmd_len != 6'd0) && (32'(cmd_len) <= MAX_LEN);
  // Length lives in the upper six header bits.
  assign len_last = header_q[7:2] - 6'd1;

  // Next-state logic: command decode, payload capture and wire sequencing.
  always_comb begin
    state_d   = state_q;
    header_d  = header_q;
    parity_d  = parity_q;
    wcnt_d    = wcnt_q;
    rcnt_d    = rcnt_q;
    gcnt_d    = gcnt_q;
    tx_done_d = 1'b0;
    err_d     = 1'b0;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid && cmd_ready) begin
          if (cmd_ok) begin
            header_d = {cmd_len, cmd_dest};
            parity_d = {cmd_len, cmd_dest};
            wcnt_d   = 6'd0;
            state_d  = StLoad;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StLoad: begin
        if (pay_valid) begin
          mem_we   = 1'b1;
          parity_d = parity_q ^ pay_data;
          wcnt_d   = wcnt_q + 6'd1;
          if (wcnt_q == len_last) state_d = StHeader;
        end
      end
      StHeader: begin
        if (!busy) begin
          rcnt_d  = 6'd0;
          state_d = StPayload;
        end
      end
      StPayload: begin
        if (!busy) begin
          if (rcnt_q == len_last) state_d = StParity;
          else                    rcnt_d  = rcnt_q + 6'd1;
        end
      end
      StParity: begin
        if (!busy) begin
          tx_done_d = 1'b1;
          cnt_d     = cnt_q + 16'd1;
          gcnt_d    = '0;
          state_d   = (GAP == 0) ? StIdle : StGap;
        end
      end
      StGap: begin
        // busy is deliberately ignored while spacing packets apart
        gcnt_d = gcnt_q + 1'b1;
        if (32'(gcnt_q) == GAP - 1) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset overrides everything.
  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (rst) begin
      state_q   <= StIdle;
      header_q  <= 8'd0;
      parity_q  <= 8'd0;
      wcnt_q    <= 6'd0;
      rcnt_q    <= 6'd0;
      gcnt_q    <= '0;
      tx_done_q <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= 16'd0;
    end else begin
      state_q   <= state_d;
      header_q  <= header_d;
      parity_q  <= parity_d;
      wcnt_q    <= wcnt_d;
      rcnt_q    <= rcnt_d;
      gcnt_q    <= gcnt_d;
      tx_done_q <= tx_done_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  // Payload buffer write port; contents need no reset.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem_q[wcnt_q] <= pay_data;
  end

  // Outputs decoded purely from registered state.
  always_comb begin
    data_out = 8'd0;
    unique case (state_q)
      StHeader:  data_out = header_q;
      StPayload: data_out = mem_q[rcnt_q];
      StParity:  data_out = parity_q;
      default:   data_out = 8'd0;
    endcase
  end

  // rst_q holds cmd_ready low for the cycle following a reset edge.
  assign cmd_ready = (state_q == StIdle) && !rst_q;
  assign pay_ready = (state_q == StLoad);
  assign pkt_valid = (state_q == StHeader) || (state_q == StPayload);
  assign tx_done   = tx_done_q;
  assign err_cmd   = err_q;
  assign pkt_count = cnt_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Bench for router_pkt_tx: directed stimulus, a transaction-level model of the
// expected wire stream, and literal expectations for each scenario.
module tb_router_pkt_tx;

  localparam int MAX_LEN = 63;
  localparam int GAP     = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_dest;
  logic [5:0]  cmd_len;
  logic        pay_valid;
  logic        pay_ready;
  logic [7:0]  pay_data;
  logic        busy;
  logic        pkt_valid;
  logic [7:0]  data_out;
  logic        tx_done;
  logic        err_cmd;
  logic [15:0] pkt_count;

  router_pkt_tx #(.MAX_LEN(MAX_LEN), .GAP(GAP)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_dest  (cmd_dest),
    .cmd_len   (cmd_len),
    .pay_valid (pay_valid),
    .pay_ready (pay_ready),
    .pay_data  (pay_data),
    .busy      (busy),
    .pkt_valid (pkt_valid),
    .data_out  (data_out),
    .tx_done   (tx_done),
    .err_cmd   (err_cmd),
    .pkt_count (pkt_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic fail_to(input string name);
    n_checks++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // ---------------- model: expected wire stream and handshake rules ----------
  logic [9:0]  tx_q[$];     // [9]=header, [8]=parity, [7:0]=byte
  logic [7:0]  pay_acc[$];
  logic [7:0]  wire_log[$]; // every byte that transferred, in order
  bit          armed = 0, rst_edge = 0, in_flight = 0, exp_err = 0, exp_tx = 0;
  int          exp_len = 0, since = 1000;
  logic [1:0]  exp_dest;
  logic [15:0] exp_count;
  logic        cr_exp, pr_exp;
  logic [9:0]  f;
  logic [7:0]  par;

  always @(negedge clk) begin
    cr_exp = !rst_edge && !in_flight && (since > GAP);
    pr_exp = in_flight && (pay_acc.size() < exp_len);
    if (armed) begin
      chk("err_cmd", err_cmd, exp_err);
      chk("tx_done", tx_done, exp_tx);
      chk("pkt_count", pkt_count, exp_count);
      chk("cmd_ready", cmd_ready, cr_exp);
      chk("pay_ready", pay_ready, pr_exp);
      if (tx_q.size() == 0) chk("idle_wire", {pkt_valid, data_out}, 9'h000);
      else chk("wire", {pkt_valid, data_out}, {!tx_q[0][8], tx_q[0][7:0]});
    end
    exp_err = 1'b0;
    exp_tx  = 1'b0;
    if (rst) begin
      armed = 1; rst_edge = 1; in_flight = 0; since = 1000; exp_count = 16'd0;
      tx_q.delete(); pay_acc.delete();
    end else if (armed) begin
      rst_edge = 0;
      if (since < 1000) since++;
      if (tx_q.size() > 0 && !busy) begin
        f = tx_q.pop_front();
        wire_log.push_back(f[7:0]);
        if (f[8]) begin
          exp_tx = 1'b1; exp_count++; since = 1; in_flight = 0;
        end
      end
      if (cmd_valid && cr_exp) begin
        if (cmd_dest != 2'd3 && cmd_len != 6'd0 && cmd_len <= MAX_LEN) begin
          in_flight = 1; exp_len = cmd_len; exp_dest = cmd_dest; pay_acc.delete();
        end else begin
          exp_err = 1'b1;
        end
      end
      if (pay_valid && pr_exp) begin
        pay_acc.push_back(pay_data);
        if (pay_acc.size() == exp_len) begin
          par = {exp_len[5:0], exp_dest};
          tx_q.push_back({2'b10, par});
          foreach (pay_acc[i]) begin
            tx_q.push_back({2'b00, pay_acc[i]});
            par ^= pay_acc[i];
          end
          tx_q.push_back({2'b01, par});
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------------------------------
  logic [7:0] pay_src[$];
  bit         hold_cmd = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] d, input logic [5:0] l);
    int n = 0;
    cmd_valid = 1'b1; cmd_dest = d; cmd_len = l;
    @(negedge clk);
    while (!cmd_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) fail_to("cmd_accept");
    tick();
    cmd_valid = hold_cmd;
  endtask

  task automatic send_pay(input bit slow);
    int n;
    foreach (pay_src[i]) begin
      if (slow) begin
        pay_valid = 1'b0;
        tick();
      end
      pay_valid = 1'b1; pay_data = pay_src[i];
      n = 0;
      @(negedge clk);
      while (!pay_ready && n < 300) begin
        @(negedge clk);
        n++;
      end
      if (n >= 300) fail_to("pay_accept");
      tick();
    end
    pay_valid = 1'b0;
  endtask

  // Entered in the header cycle; busy is high for cycles bs..bs+bl-1 and the
  // presented {pkt_valid,data_out} must equal hold through the stall.
  task automatic run_tx(input int bs, input int bl, input logic [8:0] hold, output int lat);
    int n = 0;
    busy = (bs == 0) && (bl > 0);
    while (n < 400) begin
      @(negedge clk);
      if (tx_done) break;
      if (bl > 0 && n >= bs && n <= bs + bl) chk("busy_hold", {pkt_valid, data_out}, hold);
      tick();
      n++;
      busy = (n >= bs) && (n < bs + bl);
    end
    if (n >= 400) fail_to("tx_done");
    lat = n;
    tick();
    busy = 1'b0;
  endtask

  function automatic logic [7:0] ref_parity(input logic [1:0] d, input int l);
    logic [7:0] p;
    p = {l[5:0], d};
    foreach (pay_src[i]) p ^= pay_src[i];
    return p;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1);
  end

  // ---------------- directed scenarios ---------------------------------------
  logic [7:0] exp1 [5];
  logic [7:0] p;
  int         lat;

  initial begin
    exp1 = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
    rst = 1'b1; cmd_valid = 1'b0; cmd_dest = 2'd0; cmd_len = 6'd0;
    pay_valid = 1'b0; pay_data = 8'd0; busy = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_pkt_valid", pkt_valid, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    @(negedge clk);
    chk("post_rst_cmd_ready", cmd_ready, 1'b1);
    chk("post_rst_count", pkt_count, 16'd0);
    tick();

    // Basic packet
    wire_log.delete();
    pay_src = '{8'h11, 8'h22, 8'h33};
    send_cmd(2'd1, 6'd3);
    send_pay(1'b0);
    run_tx(0, 0, 9'h000, lat);
    chk("t1_latency", lat, 5);
    chk("t1_count", pkt_count, 16'd1);
    chk("t1_bytes", wire_log.size(), 5);
    for (int i = 0; i < 5; i++) if (i < wire_log.size()) chk("t1_byte", wire_log[i], exp1[i]);
    repeat (4) tick();

    // Back-pressure on 0x22
    wire_log.delete();
    send_cmd(2'd1, 6'd3);
    send_pay(1'b0);
    run_tx(2, 3, 9'h122, lat);
    chk("t2_latency", lat, 8);
    chk("t2_count", pkt_count, 16'd2);
    chk("t2_bytes", wire_log.size(), 5);
    for (int i = 0; i < 5; i++) if (i < wire_log.size()) chk("t2_byte", wire_log[i], exp1[i]);
    repeat (4) tick();

    // Illegal commands, then a legal one
    send_cmd(2'd3, 6'd5);
    @(negedge clk);
    chk("t3_err", err_cmd, 1'b1);
    chk("t3_pay_ready", pay_ready, 1'b0);
    chk("t3_cmd_ready", cmd_ready, 1'b1);
    tick();
    @(negedge clk);
    chk("t3_err_clear", err_cmd, 1'b0);
    chk("t3_count", pkt_count, 16'd2);
    tick();
    send_cmd(2'd0, 6'd0);
    @(negedge clk);
    chk("t3_err_len0", err_cmd, 1'b1);
    tick();
    wire_log.delete();
    pay_src = '{8'hA5};
    send_cmd(2'd2, 6'd1);
    send_pay(1'b0);
    run_tx(0, 0, 9'h000, lat);
    chk("t3_bytes", wire_log.size(), 3);
    if (wire_log.size() == 3) begin
      chk("t3_header", wire_log[0], 8'h06);
      chk("t3_parity", wire_log[2], 8'hA3);
    end
    chk("t3_count_after", pkt_count, 16'd3);
    repeat (4) tick();

    // Max length, slow payload
    wire_log.delete();
    pay_src.delete();
    for (int i = 0; i < 63; i++) pay_src.push_back(8'((i * 7) + 3));
    p = ref_parity(2'd2, 63);
    send_cmd(2'd2, 6'd63);
    send_pay(1'b1);
    chk("t4_no_early_tx", wire_log.size(), 0);
    run_tx(0, 0, 9'h000, lat);
    chk("t4_bytes", wire_log.size(), 65);
    if (wire_log.size() == 65) begin
      chk("t4_header", wire_log[0], 8'hFE);
      chk("t4_last_pay", wire_log[63], pay_src[62]);
      chk("t4_parity", wire_log[64], p);
    end
    chk("t4_count", pkt_count, 16'd4);
    repeat (4) tick();

    // Reset while the 10th of 20 payload bytes is presented
    pay_src.delete();
    for (int i = 0; i < 9; i++) pay_src.push_back(8'(8'h40 + i));
    send_cmd(2'd2, 6'd20);
    send_pay(1'b0);
    pay_valid = 1'b1; pay_data = 8'h99; rst = 1'b1;
    tick();
    @(negedge clk);
    chk("t5_pkt_valid", pkt_valid, 1'b0);
    chk("t5_data_out", data_out, 8'h00);
    chk("t5_count", pkt_count, 16'd0);
    chk("t5_cmd_ready_rst", cmd_ready, 1'b0);
    tick();
    rst = 1'b0; pay_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("t5_cmd_ready", cmd_ready, 1'b1);
    tick();
    repeat (5) tick();

    // Back-to-back with cmd_valid held high; busy stalls the parity byte
    hold_cmd = 1;
    for (int k = 0; k < 3; k++) begin
      pay_src.delete();
      for (int i = 0; i < k + 2; i++) pay_src.push_back(8'(8'h5A ^ (i * 17 + k)));
      p = ref_parity(2'(k), k + 2);
      send_cmd(2'(k), 6'(k + 2));
      send_pay(1'b0);
      run_tx(k + 3, k, {1'b0, p}, lat);
      chk("t6_latency", lat, (k + 2) + 2 + k);
    end
    hold_cmd = 0;
    cmd_valid = 1'b0;
    chk("t6_count", pkt_count, 16'd3);
    repeat (6) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
